clock_gen_multi: RTL and testbench
==================================

Name: clock_gen_multi

Overview:
- Parametrised successor to the fixed divide-by-2 clock chain used to derive imem, regfile, dmem and processor clocks.
- Generates NUM_CH phase-aligned divided clocks from one master clock, each with a runtime-programmable half-period.
- Also generates per-channel rising-edge ticks and a common-edge sync tick.
- Sits at the top level between the master clock and the per-module clock inputs.

Parameters:
- NUM_CH, 4: number of output clock channels.
- CNT_W, 8: width of each half-period field and channel counter. Must satisfy CNT_W >= NUM_CH so the reset default fits.

Ports:
- clock  input  1  master clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  synchronous strobe; captures div_in and restarts all channels aligned.
- div_in  input  NUM_CH*CNT_W  half-period per channel; channel i uses bits [i*CNT_W +: CNT_W].
- clk_out  output  NUM_CH  divided clocks; each bit is driven directly from a flop.
- rise_tick  output  NUM_CH  one master-cycle pulse per channel, high in the cycle its clk_out bit has just gone 0->1.
- sync_tick  output  1  high when all active channels rise in the same cycle.

Behaviour:
- Per-channel state:
  - H_i, half-period register, CNT_W bits.
  - cnt_i, counter, CNT_W bits.
  - clk_out[i] and rise_tick[i].
- Reset (asynchronous, takes effect immediately without a clock edge):
  - H_i = 2^i, which reproduces the /2, /4, /8, /16 chain.
  - cnt_i = H_i - 1.
  - clk_out = 0, rise_tick = 0.
- Active channel (H_i != 0), on each edge without load:
  - If cnt_i == H_i - 1: cnt_i -> 0 and clk_out[i] toggles. rise_tick[i] -> 1 only when the toggle is 0->1.
  - Otherwise: cnt_i += 1 and rise_tick[i] -> 0.
  - The output period is 2*H_i master cycles at 50% duty.
- Alignment:
  - Because cnt starts at H-1, every active channel rises on the first edge after reset release or after load.
  - Channels then re-align every LCM(2*H_i) cycles.
- Disabled channel (H_i == 0): clk_out[i] = 0, rise_tick[i] = 0, cnt_i = 0, held for as long as H_i == 0.
- load:
  - Sampled on the rising edge.
  - On that edge, for every channel: H_i <- div_in field, cnt_i <- field - 1 (or 0 if the field is 0), clk_out <- 0, rise_tick <- 0.
  - load has priority over counting.
  - load held high for multiple cycles keeps all outputs low; counting resumes on the first edge after load drops.
  - A load in the middle of a high phase truncates that phase. This is required behaviour.
- sync_tick:
  - Combinational: AND of rise_tick[i] over all active channels, gated by "at least one channel active".
  - No added latency. Zero if all H_i == 0.
- Latency: clk_out and rise_tick change only on clock edges or on reset. Decode of load takes 1 cycle.
- Width rule: cnt wraps only via compare with H-1; it never overflows because H <= 2^CNT_W - 1.

Optional Feature:
- Macro: CLKGEN_GATE_EN.
- With the macro defined:
  - Adds input port ch_en, width NUM_CH, with reset-independent semantics.
  - When ch_en[i] = 0 and clk_out[i] = 1, the channel finishes its high phase normally, then holds clk_out[i] = 0 with cnt_i frozen at H_i - 1. This gives glitch-free gating with no runt pulse.
  - When ch_en[i] = 0 and clk_out[i] = 0, the channel freezes immediately.
  - On re-enable, the channel rises on the next edge (because cnt_i = H_i - 1).
  - A gated channel counts as inactive for sync_tick.
- Without the macro: no ch_en port; all channels with H != 0 run.

Test Plan:
- Reset release, defaults with NUM_CH=4 -> all four clk_out rise at edge 1. Periods are 2, 4, 8, 16 cycles. sync_tick is high at edges 1, 17, 33.
- load with div_in = {1,5,0,3} (ch3..ch0) -> next edge all outputs 0. ch0 period 6, ch1 held 0, ch2 period 10, ch3 period 2. sync_tick every 30 cycles, first on the edge after load drops.
- load asserted while ch3 (H=8) is high at cnt = 3 -> clk_out[3] = 0 next edge. All channels rise together on the following edge.
- reset asserted mid-cycle with no clock edge -> clk_out, rise_tick and sync_tick all 0 immediately. They stay 0 until the first edge after reset deasserts.
- load with all div_in = 0 -> clk_out = 0, rise_tick = 0, sync_tick never asserts over 100 cycles.
- CLKGEN_GATE_EN: deassert ch_en[2] one cycle after ch2 rises (H=4) -> ch2 stays high 3 more cycles, then low and held. Other channels are unaffected and sync_tick ignores ch2. Reassert ch_en[2] -> ch2 rises on the next edge.

Source files
------------

// File: rtl/clock_gen_multi.sv
// NUM_CH phase-aligned divided clocks with per-channel rise ticks and a common-edge sync tick.
// Define CLKGEN_GATE_EN to add the ch_en port for glitch-free per-channel gating.
module clock_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       rise_tick,
  output logic                    sync_tick
`ifdef CLKGEN_GATE_EN
  ,
  input  logic [NUM_CH-1:0]       ch_en
`endif
);

  logic [NUM_CH-1:0] active;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CNT_W-1:0] H_RST = CNT_W'(2**i);

    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_q;
    logic             rise_q;
    logic [CNT_W-1:0] fld;
    logic [CNT_W-1:0] h_m1;

    assign fld  = div_in[i*CNT_W +: CNT_W];
    assign h_m1 = h_q - 1'b1;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        h_q    <= H_RST;
        cnt_q  <= H_RST - 1'b1;
        clk_q  <= 1'b0;
        rise_q <= 1'b0;
      end else if (load) begin
        h_q    <= fld;
        cnt_q  <= (fld == '0) ? '0 : fld - 1'b1;
        clk_q  <= 1'b0;
        rise_q <= 1'b0;
      end else if (h_q == '0) begin
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        rise_q <= 1'b0;
`ifdef CLKGEN_GATE_EN
      end else if (!ch_en[i] && !clk_q) begin
        // Parked at H-1 so re-enable rises on the very next edge.
        cnt_q  <= h_m1;
        rise_q <= 1'b0;
`endif
      end else if (cnt_q == h_m1) begin
        cnt_q  <= '0;
        clk_q  <= ~clk_q;
        rise_q <= ~clk_q;
`ifdef CLKGEN_GATE_EN
        if (!ch_en[i]) cnt_q <= h_m1;
`endif
      end else begin
        cnt_q  <= cnt_q + 1'b1;
        rise_q <= 1'b0;
      end
    end

    assign clk_out[i]   = clk_q;
    assign rise_tick[i] = rise_q;
`ifdef CLKGEN_GATE_EN
    assign active[i]    = (h_q != '0) && ch_en[i];
`else
    assign active[i]    = (h_q != '0);
`endif
  end

  // Inactive channels are masked to 1 so they do not block the AND.
  assign sync_tick = (|active) && (&(rise_tick | ~active));

endmodule

// File: tb/tb_clock_gen_multi.sv
// Scoreboarded bench: stimulus pushes expected {sync,rise,clk} per cycle, a negedge monitor compares.
module tb_clock_gen_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    load;
  logic [NUM_CH*CNT_W-1:0] div_in;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       rise_tick;
  logic                    sync_tick;
`ifdef CLKGEN_GATE_EN
  logic [NUM_CH-1:0]       ch_en = '1;
`endif

  clock_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .div_in    (div_in),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
    .sync_tick (sync_tick)
`ifdef CLKGEN_GATE_EN
    ,
    .ch_en     (ch_en)
`endif
  );

  always #5 clock = ~clock;

  localparam logic [31:0] DIV_DEF  = {8'd8, 8'd4, 8'd2, 8'd1};
  localparam logic [31:0] DIV_MIX  = {8'd1, 8'd5, 8'd0, 8'd3};
  localparam logic [31:0] DIV_ZERO = 32'd0;

  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: all channels restart together, so one edge count n since restart suffices.
  int n;
  int hm[NUM_CH];

  function automatic logic [8:0] expv();
    logic [3:0] c, r, act;
    logic s;
    c = '0; r = '0; act = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hm[i] != 0) begin
        act[i] = 1'b1;
        if (n != 0) begin
          c[i] = (((n - 1) / hm[i]) % 2) == 0;
          r[i] = ((n - 1) % (2 * hm[i])) == 0;
        end
      end
    end
    s = (act != 0) && ((r | ~act) == 4'hF);
    return {s, r, c};
  endfunction

  task automatic model_defaults();
    n = 0;
    for (int i = 0; i < NUM_CH; i++) hm[i] = 1 << i;
  endtask

  // One master cycle: drive inputs, model the edge, optionally assert reset mid-cycle, push expectation.
  task automatic step(input logic ld, input logic [31:0] d, input logic rst_mid);
    load   = ld;
    div_in = d;
    @(posedge clock);
    if (reset) model_defaults();
    else if (ld) begin
      n = 0;
      for (int i = 0; i < NUM_CH; i++) hm[i] = int'(d[i*8 +: 8]);
    end else n++;
    #2;
    if (rst_mid) begin
      reset = 1'b1;
      model_defaults();
    end
    exp_q.push_back(expv());
  endtask

  initial begin : monitor
    logic [8:0] e, got;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {sync_tick, rise_tick, clk_out};
        checks++;
        if (got !== e)
          begin
            errors++;
            $display("FAIL outputs t=%0t got sync/rise/clk=%b required=%b", $time, got, e);
          end
      end
    end
  end

  initial begin : stim
    reset  = 1'b1;
    load   = 1'b0;
    div_in = DIV_DEF;
    model_defaults();
    exp_q.push_back(expv());
    @(posedge clock);
    #2;
    step(1'b0, DIV_DEF, 1'b0);

    // Default /2,/4,/8,/16 chain after reset release.
    reset = 1'b0;
    for (int k = 0; k < 40; k++) step(1'b0, DIV_DEF, 1'b0);

    // Load truncating ch3 high phase at cnt=3.
    step(1'b1, DIV_DEF, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, DIV_DEF, 1'b0);
    step(1'b1, DIV_DEF, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, DIV_DEF, 1'b0);

    // Mixed divisors with a disabled channel; load held two cycles.
    step(1'b1, DIV_MIX, 1'b0);
    step(1'b1, DIV_MIX, 1'b0);
    for (int k = 0; k < 65; k++) step(1'b0, DIV_MIX, 1'b0);

    // Asynchronous reset mid-cycle, held, then released.
    step(1'b0, DIV_MIX, 1'b1);
    step(1'b0, DIV_MIX, 1'b0);
    step(1'b0, DIV_MIX, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) step(1'b0, DIV_MIX, 1'b0);

    // All channels disabled.
    step(1'b1, DIV_ZERO, 1'b0);
    for (int k = 0; k < 100; k++) step(1'b0, DIV_ZERO, 1'b0);

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
